rom_load_ctrl: RTL and testbench
================================

// Module: rom_load_ctrl
// PURPOSE
//  Sequences the HPS ioctl download stream into the game core. Decodes each ROM byte into
//  a per-region write strobe with a region-local address, and latches the title number
//  from the title stream. Owns core reset: held through any download, on user reset, and
//  for a fixed hold period afterwards. Sits between hps_io and fpga_druaga in the top level.
// PARAMETERS
//  ROM_IDX    0     ioctl_index value carrying ROM image
//  TITLE_IDX  1     ioctl_index value carrying title byte
//  HOLD_CYC   1024  clk_sys cycles core_reset stays high after download end / user reset
//  NREG       8     number of ROM regions (fixed by package map)
// PORTS
//  clk_sys         in   1      system clock (48 MHz)
//  RESET           in   1      asynchronous, active-high reset
//  user_reset      in   1      OSD reset | reset button, synchronous level
//  ioctl_download  in   1      download window active
//  ioctl_wr        in   1      one-cycle byte strobe
//  ioctl_addr      in   25     byte address within current stream
//  ioctl_dout      in   8      byte data
//  ioctl_index     in   8      stream selector
//  rom_we          out  NREG   one-hot region write strobe
//  rom_addr        out  17     region-local byte address
//  rom_dt          out  8      byte data
//  tno             out  4      latched title number
//  title_ok        out  1      tno in 1..4
//  core_reset      out  1      reset to game core
//  busy            out  1      FSM not in RUN
//  load_err        out  1      last ROM load malformed (sticky until next ROM load)
//  rom_sum         out  16     additive checksum (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: rom_we=0, rom_addr=0, rom_dt=0, tno=0, title_ok=0, core_reset=1, busy=1,
//   load_err=0, rom_sum=0, state=HOLD, hold counter=0.
//  FSM: RUN -> LOAD on ioctl_download=1 (any index); HOLD -> LOAD likewise.
//   LOAD -> HOLD on ioctl_download=0. HOLD -> RUN when counter reaches HOLD_CYC-1.
//   RUN -> HOLD on user_reset. user_reset in HOLD reloads counter to 0.
//   user_reset in LOAD is ignored. Download wins over user_reset in the same cycle.
//  core_reset = (state!=RUN), registered. busy = core_reset.
//  ROM path (ioctl_wr & index==ROM_IDX & LOAD): decode ioctl_addr against package map.
//   Hit region k -> next cycle rom_we[k]=1 for exactly one cycle, with rom_addr=addr-BASE[k]
//   and rom_dt=dout (latency 1, no back-pressure). Miss -> no strobe, load_err<=1.
//  Byte counter: cleared on LOAD entry, +1 per accepted ROM byte, saturates at 2^25-1.
//   On LOAD->HOLD with index==ROM_IDX: count != TOTAL_BYTES sets load_err.
//   load_err is cleared on LOAD entry only when index==ROM_IDX.
//  Title path (ioctl_wr & index==TITLE_IDX & addr==0): tno<=dout[3:0];
//   title_ok<=(dout[3:0] in 1..4). Later title bytes are ignored.
//  Writes with ioctl_wr outside LOAD are ignored (no strobe).
//  RESET asserted mid-LOAD: all state to reset values. A download still active after
//   RESET release re-enters LOAD next cycle.
// CONFIGURATION
//  ROM_LOAD_CHECKSUM_EN defined: rom_sum = 16-bit wrapping sum of accepted ROM bytes,
//   cleared on ROM LOAD entry, updated with same latency as rom_we, stable in RUN.
//  Undefined: rom_sum tied 16'h0; no adder or register synthesised.
// STRUCTURE
//  Package druaga_load_pkg: state enum {RUN,LOAD,HOLD}; REG_BASE[NREG], REG_SIZE[NREG];
//   TOTAL_BYTES=25'h13400. Map: main 00000/8000, sub 08000/2000, bgchr 0A000/1000,
//   spr 0B000/8000, pal 13000/0100, bgclut 13100/0100, sprclut 13200/0100, wave 13300/0100.
//  Sub-module rom_region_dec: combinational addr -> {hit, one-hot sel, local addr}.
// TESTING
//  RESET pulse, no download -> core_reset=1 for HOLD_CYC cycles after release, then 0; busy follows.
//  Full ROM stream 0..0x133FF, index 0 -> 8 regions each strobed SIZE times;
//   addr 0x0B005 -> rom_we=8'b0000_1000, rom_addr=5, 1 cycle later; load_err=0.
//  Stream stops at 0x12FFF -> load_err=1 after download end; next full load clears it.
//  Byte at 0x13400 -> no strobe, load_err=1.
//  Title stream byte 0x02 -> tno=2, title_ok=1; byte 0x07 -> tno=7, title_ok=0; core held during stream.
//  user_reset pulse in RUN -> HOLD, counter restarts; download asserted same cycle -> LOAD.
//  With ROM_LOAD_CHECKSUM_EN: bytes 0xFF,0x02 -> rom_sum=0x0101; without it -> rom_sum=0.

Source files
------------

// File: rtl/rom_load_ctrl_pkg.sv
// Shared definitions for the Druaga ROM loader: FSM states and the ROM region map.
// The map is fixed here; rom_region_dec and rom_load_ctrl both read it.
package druaga_load_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } load_state_t;

  localparam int NREG = 8;

  localparam logic [24:0] TOTAL_BYTES = 25'h13400;

  // Regions in order: main, sub, bgchr, spr, pal, bgclut, sprclut, wave.
  localparam logic [24:0] REG_BASE [NREG] = '{
    25'h00000, 25'h08000, 25'h0A000, 25'h0B000,
    25'h13000, 25'h13100, 25'h13200, 25'h13300
  };

  localparam logic [24:0] REG_SIZE [NREG] = '{
    25'h08000, 25'h02000, 25'h01000, 25'h08000,
    25'h00100, 25'h00100, 25'h00100, 25'h00100
  };

  function automatic logic in_region(input logic [24:0] addr, input int k);
    return (addr >= REG_BASE[k]) && (addr < (REG_BASE[k] + REG_SIZE[k]));
  endfunction

endpackage

// File: rtl/rom_load_ctrl_if.sv
// ioctl download bus as driven by hps_io (master) and consumed by the loader (slave).
interface rom_load_ctrl_if;

  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;

  modport master (
    output ioctl_download,
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_dout,
    output ioctl_index
  );

  modport slave (
    input ioctl_download,
    input ioctl_wr,
    input ioctl_addr,
    input ioctl_dout,
    input ioctl_index
  );

endinterface

// File: rtl/rom_load_ctrl_region_dec.sv
// Combinational ROM address decoder: stream byte address -> region hit, one-hot select
// and region-local address.
module rom_region_dec
  import druaga_load_pkg::*;
(
  input  logic [24:0]     addr,
  output logic            hit,
  output logic [NREG-1:0] sel,
  output logic [16:0]     local_addr
);

  // Regions never overlap, so at most one iteration matches. Region offsets fit in
  // 17 bits, so the subtraction can be done on the low bits only.
  always_comb begin
    hit        = 1'b0;
    sel        = '0;
    local_addr = '0;
    for (int k = 0; k < NREG; k++) begin
      if (in_region(addr, k)) begin
        hit        = 1'b1;
        sel[k]     = 1'b1;
        local_addr = addr[16:0] - REG_BASE[k][16:0];
      end
    end
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// Sequences the ioctl download into the game core and owns core reset.
// Optional feature macro: ROM_LOAD_CHECKSUM_EN (16-bit additive checksum on rom_sum).
module rom_load_ctrl
  import druaga_load_pkg::*;
#(
  parameter logic [7:0] ROM_IDX   = 8'd0,
  parameter logic [7:0] TITLE_IDX = 8'd1,
  parameter int         HOLD_CYC  = 1024
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic              user_reset,
  rom_load_ctrl_if.slave    ioctl,
  output logic [NREG-1:0]   rom_we,
  output logic [16:0]       rom_addr,
  output logic [7:0]        rom_dt,
  output logic [3:0]        tno,
  output logic              title_ok,
  output logic              core_reset,
  output logic              busy,
  output logic              load_err,
  output logic [15:0]       rom_sum
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  load_state_t     state;
  logic [HW-1:0]   hold_cnt;
  logic [24:0]     byte_cnt;
  logic [24:0]     byte_cnt_nxt;

  logic            dec_hit;
  logic [NREG-1:0] dec_sel;
  logic [16:0]     dec_local;

  logic            rom_idx;
  logic            rom_acc;
  logic            rom_hit;
  logic            title_wr;
  logic            load_entry;
  logic            load_exit;

  rom_region_dec u_dec (
    .addr       (ioctl.ioctl_addr),
    .hit        (dec_hit),
    .sel        (dec_sel),
    .local_addr (dec_local)
  );

  assign rom_idx    = (ioctl.ioctl_index == ROM_IDX);
  assign rom_acc    = ioctl.ioctl_wr && rom_idx && (state == LOAD);
  assign rom_hit    = rom_acc && dec_hit;
  assign title_wr   = ioctl.ioctl_wr && (ioctl.ioctl_index == TITLE_IDX) &&
                      (ioctl.ioctl_addr == 25'd0) && (state == LOAD);
  assign load_entry = (state != LOAD) && ioctl.ioctl_download;
  assign load_exit  = (state == LOAD) && !ioctl.ioctl_download;

  // The final byte may arrive on the same edge the window closes, so the length
  // check looks at the count including this cycle's byte.
  assign byte_cnt_nxt = (rom_hit && (byte_cnt != '1)) ? byte_cnt + 25'd1 : byte_cnt;

  assign busy = core_reset;

  // Download always wins; user_reset only matters outside LOAD.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      core_reset <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (ioctl.ioctl_download) begin
            state      <= LOAD;
            core_reset <= 1'b1;
          end else if (user_reset) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            core_reset <= 1'b1;
          end
        end
        LOAD: begin
          if (!ioctl.ioctl_download) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (ioctl.ioctl_download) begin
            state <= LOAD;
          end else if (user_reset) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state      <= RUN;
            core_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state      <= HOLD;
          hold_cnt   <= '0;
          core_reset <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      rom_we   <= '0;
      rom_addr <= '0;
      rom_dt   <= '0;
      tno      <= '0;
      title_ok <= 1'b0;
      byte_cnt <= '0;
      load_err <= 1'b0;
    end else begin
      rom_we <= rom_hit ? dec_sel : '0;
      if (rom_hit) begin
        rom_addr <= dec_local;
        rom_dt   <= ioctl.ioctl_dout;
      end
      if (title_wr) begin
        tno      <= ioctl.ioctl_dout[3:0];
        title_ok <= (ioctl.ioctl_dout[3:0] >= 4'd1) && (ioctl.ioctl_dout[3:0] <= 4'd4);
      end
      byte_cnt <= load_entry ? 25'd0 : byte_cnt_nxt;
      if (load_entry && rom_idx) begin
        load_err <= 1'b0;
      end else if (rom_acc && !dec_hit) begin
        load_err <= 1'b1;
      end else if (load_exit && rom_idx && (byte_cnt_nxt != TOTAL_BYTES)) begin
        load_err <= 1'b1;
      end
    end
  end

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      sum_q <= '0;
    end else if (load_entry && rom_idx) begin
      sum_q <= '0;
    end else if (rom_hit) begin
      sum_q <= sum_q + {8'h00, ioctl.ioctl_dout};
    end
  end

  assign rom_sum = sum_q;
`else
  assign rom_sum = 16'h0;
`endif

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl: reset/hold timing, title and ROM streams,
// load error cases, user reset and mid-load RESET. Honours ROM_LOAD_CHECKSUM_EN.
module tb_rom_load_ctrl;

  localparam logic [7:0] ROM   = 8'd0;
  localparam logic [7:0] TITLE = 8'd1;
  localparam int REG_SZ [8] = '{32'h8000, 32'h2000, 32'h1000, 32'h8000,
                                32'h0100, 32'h0100, 32'h0100, 32'h0100};

  logic        clk_sys = 1'b0;
  logic        RESET;
  logic        user_reset;
  logic [7:0]  rom_we;
  logic [16:0] rom_addr;
  logic [7:0]  rom_dt;
  logic [3:0]  tno;
  logic        title_ok;
  logic        core_reset;
  logic        busy;
  logic        load_err;
  logic [15:0] rom_sum;

  int          compared = 0;
  int          mismatched = 0;
  int          reg_cnt [8];
  int          not_onehot;
  logic [7:0]  d;
  logic [15:0] sum_model;
  logic [15:0] sum_exp;
  logic [24:0] a25;

  rom_load_ctrl_if io ();

  rom_load_ctrl #(
    .ROM_IDX   (8'd0),
    .TITLE_IDX (8'd1),
    .HOLD_CYC  (1024)
  ) dut (
    .clk_sys    (clk_sys),
    .RESET      (RESET),
    .user_reset (user_reset),
    .ioctl      (io),
    .rom_we     (rom_we),
    .rom_addr   (rom_addr),
    .rom_dt     (rom_dt),
    .tno        (tno),
    .title_ok   (title_ok),
    .core_reset (core_reset),
    .busy       (busy),
    .load_err   (load_err),
    .rom_sum    (rom_sum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic applyStimulus(input logic dl, input logic wr, input logic [24:0] addr,
                               input logic [7:0] dout, input logic [7:0] idx);
    io.ioctl_download = dl;
    io.ioctl_wr       = wr;
    io.ioctl_addr     = addr;
    io.ioctl_dout     = dout;
    io.ioctl_index    = idx;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET      = 1'b1;
    user_reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00, ROM);
    repeat (3) @(negedge clk_sys);
    checkOutput("rst_rom_we", rom_we, 8'h00);
    checkOutput("rst_rom_addr", rom_addr, 17'd0);
    checkOutput("rst_rom_dt", rom_dt, 8'h00);
    checkOutput("rst_tno", tno, 4'd0);
    checkOutput("rst_title_ok", title_ok, 1'b0);
    checkOutput("rst_core_reset", core_reset, 1'b1);
    checkOutput("rst_busy", busy, 1'b1);
    checkOutput("rst_load_err", load_err, 1'b0);
    checkOutput("rst_rom_sum", rom_sum, 16'h0);

    RESET = 1'b0;
    repeat (1023) @(negedge clk_sys);
    checkOutput("hold_last_core_reset", core_reset, 1'b1);
    checkOutput("hold_last_busy", busy, 1'b1);
    @(negedge clk_sys);
    checkOutput("run_core_reset", core_reset, 1'b0);
    checkOutput("run_busy", busy, 1'b0);

    // Writes outside a download window must be dropped.
    applyStimulus(1'b0, 1'b1, 25'd0, 8'h04, TITLE);
    @(negedge clk_sys);
    applyStimulus(1'b0, 1'b1, 25'h10, 8'h55, ROM);
    @(negedge clk_sys);
    checkOutput("idle_title_tno", tno, 4'd0);
    checkOutput("idle_rom_we", rom_we, 8'h00);
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00, ROM);
    @(negedge clk_sys);

    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, TITLE);
    @(negedge clk_sys);
    checkOutput("title_core_reset", core_reset, 1'b1);
    applyStimulus(1'b1, 1'b1, 25'd0, 8'h02, TITLE);
    @(negedge clk_sys);
    checkOutput("title2_tno", tno, 4'd2);
    checkOutput("title2_ok", title_ok, 1'b1);
    applyStimulus(1'b1, 1'b1, 25'd1, 8'h05, TITLE);
    @(negedge clk_sys);
    checkOutput("title_later_byte_tno", tno, 4'd2);
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00, TITLE);
    @(negedge clk_sys);
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, TITLE);
    @(negedge clk_sys);
    applyStimulus(1'b1, 1'b1, 25'd0, 8'h07, TITLE);
    @(negedge clk_sys);
    checkOutput("title7_tno", tno, 4'd7);
    checkOutput("title7_ok", title_ok, 1'b0);
    checkOutput("title7_busy", busy, 1'b1);
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00, TITLE);
    @(negedge clk_sys);
    checkOutput("title_load_err", load_err, 1'b0);

    // Full ROM image, one byte per cycle.
    for (int k = 0; k < 8; k++) reg_cnt[k] = 0;
    not_onehot = 0;
    sum_model  = 16'h0;
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, ROM);
    @(negedge clk_sys);
    for (int a = 0; a < 32'h13400; a++) begin
      a25 = a[24:0];
      d   = a25[7:0] ^ a25[15:8];
      sum_model = sum_model + {8'h00, d};
      applyStimulus(1'b1, 1'b1, a25, d, ROM);
      @(negedge clk_sys);
      for (int k = 0; k < 8; k++) if (rom_we[k]) reg_cnt[k]++;
      if (!$onehot(rom_we)) not_onehot++;
      if (a == 32'h0B005) begin
        checkOutput("spr5_rom_we", rom_we, 8'b0000_1000);
        checkOutput("spr5_rom_addr", rom_addr, 17'd5);
        checkOutput("spr5_rom_dt", rom_dt, 8'hB5);
      end
      if (a == 32'h13300) begin
        checkOutput("wave0_rom_we", rom_we, 8'b1000_0000);
        checkOutput("wave0_rom_addr", rom_addr, 17'd0);
      end
    end
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, ROM);
    @(negedge clk_sys);
    checkOutput("full_we_idle", rom_we, 8'h00);
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00, ROM);
    @(negedge clk_sys);
    checkOutput("full_load_err", load_err, 1'b0);
    checkOutput("full_core_reset", core_reset, 1'b1);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("region%0d_strobes", k), reg_cnt[k], REG_SZ[k]);
    checkOutput("full_not_onehot", not_onehot, 0);
`ifdef ROM_LOAD_CHECKSUM_EN
    sum_exp = sum_model;
`else
    sum_exp = 16'h0;
`endif
    checkOutput("full_rom_sum", rom_sum, sum_exp);

    // Truncated image.
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, ROM);
    @(negedge clk_sys);
    for (int a = 0; a < 4; a++) begin
      a25 = a[24:0];
      applyStimulus(1'b1, 1'b1, a25, 8'h11, ROM);
      @(negedge clk_sys);
    end
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, ROM);
    @(negedge clk_sys);
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00, ROM);
    @(negedge clk_sys);
    checkOutput("short_load_err", load_err, 1'b1);

    // New ROM load clears the error; out-of-map byte sets it at once.
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, ROM);
    @(negedge clk_sys);
    checkOutput("reload_clears_err", load_err, 1'b0);
    applyStimulus(1'b1, 1'b1, 25'h13400, 8'hAA, ROM);
    @(negedge clk_sys);
    checkOutput("oob_rom_we", rom_we, 8'h00);
    checkOutput("oob_load_err", load_err, 1'b1);
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00, ROM);
    @(negedge clk_sys);

    // Checksum pair.
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, ROM);
    @(negedge clk_sys);
    applyStimulus(1'b1, 1'b1, 25'd0, 8'hFF, ROM);
    @(negedge clk_sys);
    applyStimulus(1'b1, 1'b1, 25'd1, 8'h02, ROM);
    @(negedge clk_sys);
    checkOutput("sum_rom_we", rom_we, 8'h01);
    checkOutput("sum_rom_addr", rom_addr, 17'd1);
    checkOutput("sum_rom_dt", rom_dt, 8'h02);
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, ROM);
    @(negedge clk_sys);
`ifdef ROM_LOAD_CHECKSUM_EN
    sum_exp = 16'h0101;
`else
    sum_exp = 16'h0;
`endif
    checkOutput("pair_rom_sum", rom_sum, sum_exp);
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00, ROM);
    @(negedge clk_sys);
    checkOutput("pair_load_err", load_err, 1'b1);
    repeat (1024) @(negedge clk_sys);
    checkOutput("pair_run_core_reset", core_reset, 1'b0);
    checkOutput("pair_run_rom_sum", rom_sum, sum_exp);

    // user_reset in RUN, then a reload of the counter while in HOLD.
    user_reset = 1'b1;
    @(negedge clk_sys);
    user_reset = 1'b0;
    checkOutput("ures_core_reset", core_reset, 1'b1);
    repeat (500) @(negedge clk_sys);
    user_reset = 1'b1;
    @(negedge clk_sys);
    user_reset = 1'b0;
    repeat (1023) @(negedge clk_sys);
    checkOutput("ures_hold_last", core_reset, 1'b1);
    @(negedge clk_sys);
    checkOutput("ures_run", core_reset, 1'b0);

    // Download and user_reset together: download wins.
    user_reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, TITLE);
    @(negedge clk_sys);
    user_reset = 1'b0;
    checkOutput("both_busy", busy, 1'b1);
    applyStimulus(1'b1, 1'b1, 25'd0, 8'h03, TITLE);
    @(negedge clk_sys);
    checkOutput("both_tno", tno, 4'd3);
    checkOutput("both_title_ok", title_ok, 1'b1);

    // RESET mid-download; the still-open window re-enters LOAD.
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, TITLE);
    RESET = 1'b1;
    @(negedge clk_sys);
    checkOutput("midrst_tno", tno, 4'd0);
    checkOutput("midrst_core_reset", core_reset, 1'b1);
    RESET = 1'b0;
    @(negedge clk_sys);
    applyStimulus(1'b1, 1'b1, 25'd0, 8'h01, TITLE);
    @(negedge clk_sys);
    checkOutput("relaunch_tno", tno, 4'd1);
    checkOutput("relaunch_title_ok", title_ok, 1'b1);
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00, ROM);
    @(negedge clk_sys);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
